// File: rtl/regfile_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl_if
// Brief    : Bundles the datapath-side request/response signals and the
//            register-file-side port of regfile_access_ctrl.
//            slave  = controller view, master = datapath/register-file view.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_access_ctrl_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Writeback queue side
    logic                Wr_valid;
    logic                Wr_ready;
    logic [ADDR_W-1:0]   Wr_addr;
    logic [DATA_W-1:0]   Wr_data;

    // Operand read side
    logic                Rd_valid;
    logic                Rd_ready;
    logic [ADDR_W-1:0]   Rd_addr_1;
    logic [ADDR_W-1:0]   Rd_addr_2;
    logic                Rd_resp_valid;
    logic [DATA_W-1:0]   Rd_data_1;
    logic [DATA_W-1:0]   Rd_data_2;

    // Status
    logic                Busy;
    logic [c_CNT_W-1:0]  Fifo_count;

    // Register file port
    logic [ADDR_W-1:0]   Read_1;
    logic [ADDR_W-1:0]   Read_2;
    logic [ADDR_W-1:0]   Address_to_write;
    logic [DATA_W-1:0]   Data_to_write;
    logic                Signal_write;
    logic [DATA_W-1:0]   Out_1;
    logic [DATA_W-1:0]   Out_2;

    modport slave (
        input  Wr_valid, Wr_addr, Wr_data,
        input  Rd_valid, Rd_addr_1, Rd_addr_2,
        input  Out_1, Out_2,
        output Wr_ready, Rd_ready, Rd_resp_valid, Rd_data_1, Rd_data_2,
        output Busy, Fifo_count,
        output Read_1, Read_2, Address_to_write, Data_to_write, Signal_write
    );

    modport master (
        output Wr_valid, Wr_addr, Wr_data,
        output Rd_valid, Rd_addr_1, Rd_addr_2,
        output Out_1, Out_2,
        input  Wr_ready, Rd_ready, Rd_resp_valid, Rd_data_1, Rd_data_2,
        input  Busy, Fifo_count,
        input  Read_1, Read_2, Address_to_write, Data_to_write, Signal_write
    );
endinterface
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl
// Brief    : Sequences queued writebacks and two-operand reads onto a
//            single-operation-per-clock register file port. Reads win over
//            draining unless the queue is full; read data returns one cycle
//            after issue.
//            Optional macro REGFILE_FORWARD_EN: forward the youngest queued
//            write on an address match instead of interlocking the read.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5
) (
    input  wire logic             Clock_in,
    input  wire logic             Signal_reset,
    regfile_access_ctrl_if.slave  bus
);
    localparam int                  c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(FIFO_DEPTH);

    // Queue storage and bookkeeping
    logic [ADDR_W-1:0]   r_q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_q_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // Response stage
    logic                r_resp_valid;
    logic                r_zero_1;
    logic                r_zero_2;

    logic                w_full;
    logic                w_empty;
    logic                w_stall;
    logic                w_rd_issue;
    logic                w_drain;
    logic                w_enq;
    logic [FIFO_DEPTH-1:0] w_entry_vld;
    logic [FIFO_DEPTH-1:0] w_hit_1;
    logic [FIFO_DEPTH-1:0] w_hit_2;
    logic [DATA_W-1:0]   w_data_1;
    logic [DATA_W-1:0]   w_data_2;

    // Per-entry occupancy and address match against the current read request
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [c_PTR_W-1:0] w_offset;
        assign w_offset        = c_PTR_W'(gi) - r_rd_ptr;
        assign w_entry_vld[gi] = ({1'b0, w_offset} < r_count);
        assign w_hit_1[gi]     = w_entry_vld[gi] && (bus.Rd_addr_1 != '0)
                                 && (r_q_addr[gi] == bus.Rd_addr_1);
        assign w_hit_2[gi]     = w_entry_vld[gi] && (bus.Rd_addr_2 != '0)
                                 && (r_q_addr[gi] == bus.Rd_addr_2);
    end

`ifdef REGFILE_FORWARD_EN
    logic                w_fwd_hit_1;
    logic                w_fwd_hit_2;
    logic [DATA_W-1:0]   w_fwd_data_1;
    logic [DATA_W-1:0]   w_fwd_data_2;
    logic                r_fwd_hit_1;
    logic                r_fwd_hit_2;
    logic [DATA_W-1:0]   r_fwd_data_1;
    logic [DATA_W-1:0]   r_fwd_data_2;

    assign w_stall = 1'b0;

    // Walk head to tail so the youngest matching entry is the one kept
    always_comb begin
        w_fwd_hit_1  = 1'b0;
        w_fwd_hit_2  = 1'b0;
        w_fwd_data_1 = '0;
        w_fwd_data_2 = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (w_hit_1[r_rd_ptr + c_PTR_W'(k)]) begin
                w_fwd_hit_1  = 1'b1;
                w_fwd_data_1 = r_q_data[r_rd_ptr + c_PTR_W'(k)];
            end
            if (w_hit_2[r_rd_ptr + c_PTR_W'(k)]) begin
                w_fwd_hit_2  = 1'b1;
                w_fwd_data_2 = r_q_data[r_rd_ptr + c_PTR_W'(k)];
            end
        end
    end

    // Capture the forward decision at the issue edge
    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            r_fwd_hit_1  <= 1'b0;
            r_fwd_hit_2  <= 1'b0;
            r_fwd_data_1 <= '0;
            r_fwd_data_2 <= '0;
        end else if (w_rd_issue) begin
            r_fwd_hit_1  <= w_fwd_hit_1;
            r_fwd_hit_2  <= w_fwd_hit_2;
            r_fwd_data_1 <= w_fwd_data_1;
            r_fwd_data_2 <= w_fwd_data_2;
        end
    end
`else
    // Hold the read while any queued write targets one of its operands
    assign w_stall = (|w_hit_1) || (|w_hit_2);
`endif

    // Arbitration: a full queue forces a drain; otherwise reads go first.
    // A write accepted alongside a read is invisible to it because the
    // match above only looks at entries already in the queue.
    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_rd_issue = !Signal_reset && bus.Rd_valid && !w_full && !w_stall;
    assign w_drain    = !Signal_reset && (w_full || (!w_empty && !w_rd_issue));
    assign w_enq      = !Signal_reset && bus.Wr_valid && !w_full
                        && (bus.Wr_addr != '0);

    assign bus.Wr_ready         = !w_full;
    assign bus.Rd_ready         = w_rd_issue;
    assign bus.Signal_write     = w_drain;
    assign bus.Read_1           = w_rd_issue ? bus.Rd_addr_1 : '0;
    assign bus.Read_2           = w_rd_issue ? bus.Rd_addr_2 : '0;
    assign bus.Address_to_write = r_q_addr[r_rd_ptr];
    assign bus.Data_to_write    = r_q_data[r_rd_ptr];
    assign bus.Busy             = !w_empty || r_resp_valid;
    assign bus.Fifo_count       = r_count;
    assign bus.Rd_resp_valid    = r_resp_valid;
    assign bus.Rd_data_1        = w_data_1;
    assign bus.Rd_data_2        = w_data_2;

    // Queue pointers and occupancy; enqueue and pop may coincide
    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_drain);
        end
    end

    // Queue payload storage; contents are don't-care until enqueued
    always_ff @(posedge Clock_in) begin
        if (w_enq) begin
            r_q_addr[r_wr_ptr] <= bus.Wr_addr;
            r_q_data[r_wr_ptr] <= bus.Wr_data;
        end
    end

    // Response stage: one-cycle valid pulse plus zero-register flags
    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            r_resp_valid <= 1'b0;
            r_zero_1     <= 1'b0;
            r_zero_2     <= 1'b0;
        end else begin
            r_resp_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_zero_1 <= (bus.Rd_addr_1 == '0);
                r_zero_2 <= (bus.Rd_addr_2 == '0);
            end
        end
    end

    // Operand select in the response cycle; outputs read zero otherwise
    always_comb begin
        w_data_1 = '0;
        w_data_2 = '0;
        if (r_resp_valid) begin
            if (r_zero_1)          w_data_1 = '0;
`ifdef REGFILE_FORWARD_EN
            else if (r_fwd_hit_1)  w_data_1 = r_fwd_data_1;
`endif
            else                   w_data_1 = bus.Out_1;

            if (r_zero_2)          w_data_2 = '0;
`ifdef REGFILE_FORWARD_EN
            else if (r_fwd_hit_2)  w_data_2 = r_fwd_data_2;
`endif
            else                   w_data_2 = bus.Out_2;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_access_ctrl
// Brief    : Directed self-checking bench for regfile_access_ctrl with a
//            behavioural register file attached to its register port.
//            Expectations follow REGFILE_FORWARD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_access_ctrl;
    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              model_init;
    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] regs [32];

    regfile_access_ctrl_if #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W)
    ) bus ();

    regfile_access_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W)
    ) dut (
        .Clock_in     (clk),
        .Signal_reset (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Register file: r0 deliberately non-zero so zero masking is observable
    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 0) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
        end else if (bus.Signal_write) begin
            regs[bus.Address_to_write] <= bus.Data_to_write;
        end
        bus.Out_1 <= regs[bus.Read_1];
        bus.Out_2 <= regs[bus.Read_2];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.Busy && n < 50) begin
            tick();
            n++;
        end
        chk(tag, bus.Busy, 1'b0);
    endtask

    // Hold a read until issued, then check the stall count and response
    task automatic do_read(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2, input int est);
        int stalls = 0;
        bus.Rd_valid  = 1'b1;
        bus.Rd_addr_1 = a1;
        bus.Rd_addr_2 = a2;
        #1;
        while (!bus.Rd_ready && stalls < 20) begin
            tick();
            #1;
            stalls++;
        end
        chk({tag, "_stalls"}, stalls, est);
        chk({tag, "_read1"}, bus.Read_1, a1);
        tick();
        bus.Rd_valid = 1'b0;
        chk({tag, "_rv"}, bus.Rd_resp_valid, 1'b1);
        chk({tag, "_d1"}, bus.Rd_data_1, e1);
        chk({tag, "_d2"}, bus.Rd_data_2, e2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        // Reset cycle with live requests that must be ignored
        rst           = 1'b1;
        model_init    = 1'b1;
        bus.Wr_valid  = 1'b1;
        bus.Wr_addr   = 5'd9;
        bus.Wr_data   = 32'h5555_5555;
        bus.Rd_valid  = 1'b1;
        bus.Rd_addr_1 = 5'd9;
        bus.Rd_addr_2 = 5'd10;
        #2;
        chk("rst_sigwr", bus.Signal_write, 1'b0);
        chk("rst_rdready", bus.Rd_ready, 1'b0);
        tick();
        chk("rst_count", bus.Fifo_count, 0);
        chk("rst_wrready", bus.Wr_ready, 1'b1);
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_rv", bus.Rd_resp_valid, 1'b0);
        chk("rst_d1", bus.Rd_data_1, 0);
        rst          = 1'b0;
        model_init   = 1'b0;
        bus.Wr_valid = 1'b0;
        bus.Rd_valid = 1'b0;

        // Write r5 then read (5,0)
        bus.Wr_valid = 1'b1;
        bus.Wr_addr  = 5'd5;
        bus.Wr_data  = 32'h1234_5678;
        #1;
        chk("w5_wrready", bus.Wr_ready, 1'b1);
        chk("w5_sigwr_empty", bus.Signal_write, 1'b0);
        tick();
        bus.Wr_valid = 1'b0;
        chk("w5_count", bus.Fifo_count, 1);
        chk("w5_busy", bus.Busy, 1'b1);
        #1;
        chk("w5_sigwr", bus.Signal_write, 1'b1);
        chk("w5_waddr", bus.Address_to_write, 5);
        chk("w5_wdata", bus.Data_to_write, 32'h1234_5678);
        tick();
        wait_idle("w5_idle");
        do_read("r5", 5'd5, 5'd0, 32'h1234_5678, 32'h0, 0);
        tick();
        chk("r5_pulse", bus.Rd_resp_valid, 1'b0);

        // Write to r0 is dropped; r0 reads as zero
        bus.Wr_valid = 1'b1;
        bus.Wr_addr  = 5'd0;
        bus.Wr_data  = 32'hFFFF_FFFF;
        tick();
        bus.Wr_valid = 1'b0;
        chk("w0_count", bus.Fifo_count, 0);
        #1;
        chk("w0_sigwr", bus.Signal_write, 1'b0);
        tick();
        do_read("r0", 5'd0, 5'd0, 32'h0, 32'h0, 0);

        // Two queued writes to r3, kept queued by an unrelated read
        tick();
        bus.Wr_valid = 1'b1;
        bus.Wr_addr  = 5'd3;
        bus.Wr_data  = 32'd1;
        tick();
        bus.Wr_data   = 32'd2;
        bus.Rd_valid  = 1'b1;
        bus.Rd_addr_1 = 5'd7;
        bus.Rd_addr_2 = 5'd8;
        #1;
        chk("haz_pre_rdy", bus.Rd_ready, 1'b1);
        chk("haz_pre_sigwr", bus.Signal_write, 1'b0);
        tick();
        bus.Wr_valid = 1'b0;
        chk("haz_count", bus.Fifo_count, 2);
        chk("haz_pre_rv", bus.Rd_resp_valid, 1'b1);
        chk("haz_pre_d1", bus.Rd_data_1, 32'hA000_0007);
        chk("haz_pre_d2", bus.Rd_data_2, 32'hA000_0008);
`ifdef REGFILE_FORWARD_EN
        do_read("haz", 5'd3, 5'd3, 32'd2, 32'd2, 0);
`else
        do_read("haz", 5'd3, 5'd3, 32'd2, 32'd2, 2);
`endif
        wait_idle("haz_idle");
        do_read("haz_rb", 5'd3, 5'd0, 32'd2, 32'h0, 0);

        // Fill to full with reads pending, then wrap the pointers
        bus.Rd_valid  = 1'b1;
        bus.Rd_addr_1 = 5'd20;
        bus.Rd_addr_2 = 5'd21;
        for (int i = 1; i <= 4; i++) begin
            bus.Wr_valid = 1'b1;
            bus.Wr_addr  = 5'(i);
            bus.Wr_data  = 32'h0000_1100 + 32'(i);
            #1;
            chk("fill_rdready", bus.Rd_ready, 1'b1);
            tick();
        end
        bus.Wr_addr = 5'd5;
        bus.Wr_data = 32'h0000_1105;
        chk("full_count", bus.Fifo_count, 4);
        chk("full_wrready", bus.Wr_ready, 1'b0);
        #1;
        chk("full_rdready", bus.Rd_ready, 1'b0);
        chk("full_sigwr", bus.Signal_write, 1'b1);
        chk("full_waddr", bus.Address_to_write, 1);
        tick();
        bus.Rd_valid = 1'b0;
        chk("pop_count", bus.Fifo_count, 3);
        #1;
        chk("enqpop_wrready", bus.Wr_ready, 1'b1);
        chk("enqpop_sigwr", bus.Signal_write, 1'b1);
        chk("enqpop_waddr", bus.Address_to_write, 2);
        tick();
        chk("enqpop_count", bus.Fifo_count, 3);
        bus.Wr_addr  = 5'd6;
        bus.Wr_data  = 32'h0000_1106;
        bus.Rd_valid = 1'b1;
        #1;
        chk("refill_rdready", bus.Rd_ready, 1'b1);
        chk("refill_sigwr", bus.Signal_write, 1'b0);
        tick();
        chk("refill_count", bus.Fifo_count, 4);
        bus.Wr_valid = 1'b0;
        bus.Rd_valid = 1'b0;
        #1;
        chk("refull_waddr", bus.Address_to_write, 3);
        tick();
        wait_idle("fill_idle");
        do_read("wrap12", 5'd1, 5'd2, 32'h0000_1101, 32'h0000_1102, 0);
        do_read("wrap34", 5'd3, 5'd4, 32'h0000_1103, 32'h0000_1104, 0);
        do_read("wrap56", 5'd5, 5'd6, 32'h0000_1105, 32'h0000_1106, 0);

        // Reset with three queued writes and a read in flight
        bus.Rd_valid  = 1'b1;
        bus.Rd_addr_1 = 5'd20;
        bus.Rd_addr_2 = 5'd21;
        for (int i = 10; i <= 12; i++) begin
            bus.Wr_valid = 1'b1;
            bus.Wr_addr  = 5'(i);
            bus.Wr_data  = 32'hBAD0_0000 + 32'(i);
            tick();
        end
        bus.Wr_valid = 1'b0;
        chk("mrst_pre_count", bus.Fifo_count, 3);
        rst = 1'b1;
        #1;
        chk("mrst_rdready", bus.Rd_ready, 1'b0);
        chk("mrst_sigwr", bus.Signal_write, 1'b0);
        tick();
        rst          = 1'b0;
        bus.Rd_valid = 1'b0;
        chk("mrst_count", bus.Fifo_count, 0);
        chk("mrst_rv", bus.Rd_resp_valid, 1'b0);
        chk("mrst_busy", bus.Busy, 1'b0);
        tick();
        do_read("mrst_r1011", 5'd10, 5'd11, 32'hA000_000A, 32'hA000_000B, 0);
        do_read("mrst_r12", 5'd12, 5'd0, 32'hA000_000C, 32'h0, 0);

        // Same-cycle read and write to r7: read sees the old value
        bus.Wr_valid = 1'b1;
        bus.Wr_addr  = 5'd7;
        bus.Wr_data  = 32'h7777_7777;
        do_read("raw_old", 5'd7, 5'd0, 32'hA000_0007, 32'h0, 0);
        bus.Wr_valid = 1'b0;
        chk("raw_count", bus.Fifo_count, 1);
        wait_idle("raw_idle");
        do_read("raw_new", 5'd7, 5'd0, 32'h7777_7777, 32'h0, 0);

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
